// File: rtl/cache_pkg.sv
// cache_pkg: shared state encoding, line geometry and address field helpers for the refill controller.
package cache_pkg;
  typedef enum logic [2:0] {IDLE, RD_REQ, FILL, COMMIT, RD_DONE, WR_REQ, WR_WAIT} state_t;
  localparam int LINE_WORDS = 4;
  localparam logic [2:0] COUNTER_COMMIT = 3'd5;
  localparam int OFFSET_LSB = 0;
  localparam int INDEX_LSB = 2;
  localparam int TAG_LSB = 4;
  function automatic logic [1:0] offset_of(input logic [31:0] a);
    return a[OFFSET_LSB +: 2];
  endfunction
  function automatic logic [1:0] index_of(input logic [31:0] a);
    return a[INDEX_LSB +: 2];
  endfunction
  function automatic logic [27:0] tag_of(input logic [31:0] a);
    return a[31:TAG_LSB];
  endfunction
endpackage

// File: rtl/mem_timeout_timer.sv
// mem_timeout_timer: 8-bit wait counter with clear/enable that flags when it reaches LIMIT.
module mem_timeout_timer #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] count_q, count_d;
  always_comb count_d = clr ? 8'd0 : en ? count_q + 8'd1 : count_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) count_q <= 8'd0;
    else count_q <= count_d;
  assign expired = count_q == LIMIT;
endmodule

// File: rtl/cache_refill_controller.sv
// cache_refill_controller: read-miss wrapping burst refill and write-through sequencing for a 4x4 direct-mapped cache.
module cache_refill_controller
  import cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              hit,
  output logic [2:0]        counter,
  output logic [DATA_W-1:0] memory_word,
  output logic              cpu_busy,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_wdone,
  output logic              err
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0] beat_q, beat_d;
  logic err_q, err_d;
  logic expired, timer_en, timer_clr;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    beat_d = beat_q;
    err_d = err_q;
    counter = 3'd0;
    cpu_busy = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_read) begin
          cpu_busy = !hit;
          err_d = err_q | cpu_write;
          if (!hit) begin
            state_d = RD_REQ;
            addr_d = cpu_addr;
          end
        end else if (cpu_write) begin
          cpu_busy = 1'b1;
          state_d = WR_REQ;
          addr_d = cpu_addr;
          wdata_d = cpu_wdata;
        end
      end
      RD_REQ: begin
        cpu_busy = 1'b1;
        if (mem_ack) begin
          state_d = FILL;
          beat_d = 2'd0;
        end
      end
      FILL: begin
        cpu_busy = 1'b1;
        if (mem_rvalid) begin
          counter = {1'b0, beat_q} + 3'd1;
          beat_d = beat_q + 2'd1;
          state_d = beat_q == 2'(LINE_WORDS - 1) ? COMMIT : FILL;
        end
      end
      COMMIT: begin
        cpu_busy = 1'b1;
        counter = COUNTER_COMMIT;
        state_d = RD_DONE;
      end
      RD_DONE: state_d = IDLE;
      WR_REQ: begin
        cpu_busy = !(mem_ack && mem_wdone);
        if (mem_ack) state_d = mem_wdone ? IDLE : WR_WAIT;
      end
      WR_WAIT: begin
        cpu_busy = !mem_wdone;
        if (mem_wdone) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && cpu_addr != addr_q) err_d = 1'b1;
    // An abandoned refill never reaches COMMIT, so the line stays invalid.
    if (expired) begin
      err_d = 1'b1;
      counter = 3'd0;
      cpu_busy = 1'b0;
      state_d = IDLE;
    end
  end
  assign timer_en = state_q == RD_REQ || state_q == FILL || state_q == WR_REQ || state_q == WR_WAIT;
  assign timer_clr = state_d != state_q || mem_rvalid;
  mem_timeout_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk(clk), .rst(rst), .clr(timer_clr), .en(timer_en), .expired(expired)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      beat_q <= 2'd0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      beat_q <= beat_d;
      err_q <= err_d;
    end
  assign memory_word = mem_rdata;
  assign mem_rd_req = state_q == RD_REQ;
  assign mem_wr_req = state_q == WR_REQ;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign err = err_q;
endmodule
